// File: rtl/bus_pkg.sv
// Shared definitions for the core data bus controller: FSM encoding and defaults.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  localparam int BUS_TIMEOUT_DEFAULT = 15;
  localparam int BUS_CNT_W           = 8;

endpackage

// File: rtl/bus_addr_decode.sv
// Splits a core byte address into slave index and in-region offset and flags
// requests that cannot be routed (index out of range or empty byte mask).
module bus_addr_decode #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TRANSFER_WIDTH = 4,
  parameter int N_SLAVES       = 4
) (
  input  logic [ADDR_WIDTH-1:0]                      addr_i,
  input  logic [TRANSFER_WIDTH-1:0]                  transfer_i,
  output logic [$clog2(N_SLAVES)-1:0]                idx_o,
  output logic [ADDR_WIDTH-$clog2(N_SLAVES)-1:0]     off_o,
  output logic                                       err_o
);

  localparam int SEL_BITS = $clog2(N_SLAVES);

  assign idx_o = addr_i[ADDR_WIDTH-1 -: SEL_BITS];
  assign off_o = addr_i[ADDR_WIDTH-SEL_BITS-1:0];
  // Non-power-of-two slave counts leave unmapped regions at the top of the map.
  assign err_o = (int'(idx_o) >= N_SLAVES) || (transfer_i == '0);

endmodule

// File: rtl/data_bus_ctrl.sv
// Core-side data bus controller routing single transfers to N_SLAVES regions
// (data memory is slave 0) with a per-access wait timeout.
module data_bus_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TRANSFER_WIDTH = 4,
  parameter int N_SLAVES       = 4,
  parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    req_i,
  input  logic                                    we_i,
  input  logic [ADDR_WIDTH-1:0]                   addr_i,
  input  logic [DATA_WIDTH-1:0]                   wdata_i,
  input  logic [TRANSFER_WIDTH-1:0]               transfer_i,
  output logic [DATA_WIDTH-1:0]                   rdata_o,
  output logic                                    ready_o,
  output logic                                    err_o,
  output logic                                    busy_o,
  output logic [N_SLAVES-1:0]                     sel_o,
  output logic                                    s_we_o,
  output logic [ADDR_WIDTH-$clog2(N_SLAVES)-1:0]  s_addr_o,
  output logic [DATA_WIDTH-1:0]                   s_wdata_o,
  output logic [TRANSFER_WIDTH-1:0]               s_transfer_o,
  input  logic [N_SLAVES*DATA_WIDTH-1:0]          s_rdata_i,
  input  logic [N_SLAVES-1:0]                     s_ready_i
);

  localparam int SEL_BITS = $clog2(N_SLAVES);
  localparam int OFF_W    = ADDR_WIDTH - SEL_BITS;
  localparam logic [BUS_CNT_W-1:0] CNT_LAST = BUS_CNT_W'(TIMEOUT_CYCLES - 1);

  bus_state_e                  state_q, state_d;
  logic                        we_q;
  logic [SEL_BITS-1:0]         idx_q;
  logic [OFF_W-1:0]            off_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic [TRANSFER_WIDTH-1:0]   transfer_q;
  logic                        flag_q, flag_d;
  logic [BUS_CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic                        ready_q, ready_d;
  logic                        err_q, err_d;

  logic [SEL_BITS-1:0]         dec_idx;
  logic [OFF_W-1:0]            dec_off;
  logic                        dec_err;
  logic                        accept;

  bus_addr_decode #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .TRANSFER_WIDTH(TRANSFER_WIDTH),
    .N_SLAVES      (N_SLAVES)
  ) u_decode (
    .addr_i    (addr_i),
    .transfer_i(transfer_i),
    .idx_o     (dec_idx),
    .off_o     (dec_off),
    .err_o     (dec_err)
  );

  assign accept = (state_q == ST_IDLE) && req_i;

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          cnt_d  = '0;
          flag_d = dec_err;
          if (dec_err) begin
            state_d = ST_RESP;
            rdata_d = '0;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (s_ready_i[idx_q]) begin
          state_d = ST_RESP;
          flag_d  = 1'b0;
          rdata_d = we_q ? '0 : s_rdata_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          flag_d  = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        // Response strobe is registered, so it lands on the edge leaving RESP.
        state_d = ST_IDLE;
        ready_d = 1'b1;
        err_d   = flag_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      flag_q     <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      transfer_q <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      if (accept) begin
        we_q       <= we_i;
        idx_q      <= dec_idx;
        off_q      <= dec_off;
        wdata_q    <= wdata_i;
        transfer_q <= transfer_i;
      end
    end
  end

  // Slave strobes derive only from registered state, so they are glitch-free
  // for the whole ACCESS state and drop together with an async reset.
  always_comb begin
    sel_o        = '0;
    s_we_o       = 1'b0;
    s_transfer_o = '0;
    if (state_q == ST_ACCESS) begin
      sel_o        = {{(N_SLAVES-1){1'b0}}, 1'b1} << idx_q;
      s_we_o       = we_q;
      s_transfer_o = transfer_q;
    end
  end

  assign s_addr_o  = off_q;
  assign s_wdata_o = wdata_q;
  assign rdata_o   = rdata_q;
  assign ready_o   = ready_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Table-driven bench for data_bus_ctrl with a response scoreboard and a
// latency-programmable slave model.
module tb_data_bus_ctrl;

  logic         clk;
  logic         rst_n;
  logic         req_i;
  logic         we_i;
  logic [9:0]   addr_i;
  logic [31:0]  wdata_i;
  logic [3:0]   transfer_i;
  logic [31:0]  rdata_o;
  logic         ready_o;
  logic         err_o;
  logic         busy_o;
  logic [3:0]   sel_o;
  logic         s_we_o;
  logic [7:0]   s_addr_o;
  logic [31:0]  s_wdata_o;
  logic [3:0]   s_transfer_o;
  logic [127:0] s_rdata_i;
  logic [3:0]   s_ready_i;

  data_bus_ctrl #(
    .ADDR_WIDTH    (10),
    .DATA_WIDTH    (32),
    .TRANSFER_WIDTH(4),
    .N_SLAVES      (4),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .transfer_i  (transfer_i),
    .rdata_o     (rdata_o),
    .ready_o     (ready_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .sel_o       (sel_o),
    .s_we_o      (s_we_o),
    .s_addr_o    (s_addr_o),
    .s_wdata_o   (s_wdata_o),
    .s_transfer_o(s_transfer_o),
    .s_rdata_i   (s_rdata_i),
    .s_ready_i   (s_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Selected slave answers after cur_lat wait cycles; unselected slaves hold
  // ready high so any leakage from them would show up as an early response.
  int cur_lat = 0;
  int acc_cnt = 0;
  assign s_rdata_i = {32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF, 32'hA5A5A5A5};
  always_comb begin
    for (int k = 0; k < 4; k++)
      s_ready_i[k] = sel_o[k] ? (acc_cnt >= cur_lat) : 1'b1;
  end
  always @(posedge clk) acc_cnt <= (sel_o != 4'b0) ? acc_cnt + 1 : 0;

  logic [32:0] sb[$];
  logic [32:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ready_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready_o=1, expected no response");
      end else begin
        mon_exp = sb.pop_front();
        check("resp_rdata", 64'(rdata_o), 64'(mon_exp[32:1]));
        check("resp_err", 64'(err_o), 64'(mon_exp[0]));
      end
    end
  end

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  tf;
    int          lat;
    logic [3:0]  sel;
    logic [7:0]  saddr;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } vec_t;

  vec_t vecs[7];

  task automatic do_txn(input vec_t v);
    int   cyc;
    int   selc;
    int   selbad;
    logic seen;
    @(negedge clk);
    cur_lat    = v.lat;
    req_i      = 1'b1;
    we_i       = v.we;
    addr_i     = v.addr;
    wdata_i    = v.wdata;
    transfer_i = v.tf;
    sb.push_back({v.rdata, v.err});
    @(negedge clk);
    req_i  = 1'b0;
    cyc    = 1;
    selc   = 0;
    selbad = 0;
    seen   = 1'b0;
    while (cyc <= 40) begin
      if (sel_o != 4'b0) begin
        selc++;
        if (sel_o !== v.sel || s_addr_o !== v.saddr || s_transfer_o !== v.tf ||
            s_we_o !== v.we || s_wdata_o !== v.wdata)
          selbad++;
      end
      if (ready_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check("ready_seen", 64'(seen), 64'd1);
    check("latency", 64'(cyc), 64'(v.acc + 2));
    check("sel_cycles", 64'(selc), 64'(v.acc));
    check("strobe_values", 64'(selbad), 64'd0);
    @(negedge clk);
    check("ready_one_cycle", 64'(ready_o), 64'd0);
    check("rdata_hold", 64'(rdata_o), 64'(v.rdata));
  endtask

  initial begin
    int rcnt;
    int selbad;
    int wait_cyc;

    vecs[0] = '{1'b0, 10'h104, 32'h0,        4'hF, 0,   4'b0010, 8'h04, 32'hDEADBEEF, 1'b0, 1};
    vecs[1] = '{1'b1, 10'h010, 32'h000000AB, 4'h1, 3,   4'b0001, 8'h10, 32'h0,        1'b0, 4};
    vecs[2] = '{1'b0, 10'h300, 32'h0,        4'hF, 255, 4'b1000, 8'h00, 32'h0,        1'b1, 15};
    vecs[3] = '{1'b1, 10'h000, 32'h55,       4'h0, 0,   4'b0000, 8'h00, 32'h0,        1'b1, 0};
    vecs[4] = '{1'b0, 10'h2FC, 32'h0,        4'h3, 1,   4'b0100, 8'hFC, 32'h12345678, 1'b0, 2};
    vecs[5] = '{1'b0, 10'h3FF, 32'h0,        4'hF, 14,  4'b1000, 8'hFF, 32'hCAFEF00D, 1'b0, 15};
    vecs[6] = '{1'b1, 10'h200, 32'h11223344, 4'hC, 0,   4'b0100, 8'h00, 32'h0,        1'b0, 1};

    rst_n      = 1'b1;
    req_i      = 1'b1;
    we_i       = 1'b0;
    addr_i     = 10'h104;
    wdata_i    = 32'h0;
    transfer_i = 4'hF;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_sel", 64'(sel_o), 64'd0);
    check("rst_s_we", 64'(s_we_o), 64'd0);
    check("rst_s_transfer", 64'(s_transfer_o), 64'd0);
    check("rst_rdata", 64'(rdata_o), 64'd0);

    // Request already pending at release is taken on the first live edge.
    rst_n = 1'b1;
    sb.push_back({32'hDEADBEEF, 1'b0});
    @(negedge clk);
    req_i = 1'b0;
    check("first_req_busy", 64'(busy_o), 64'd1);
    check("first_req_sel", 64'(sel_o), 64'b0010);
    wait_cyc = 0;
    while (!ready_o && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("first_req_ready", 64'(ready_o), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) do_txn(vecs[i]);

    // Reset during the second wait cycle of an access to a silent slave.
    @(negedge clk);
    cur_lat    = 255;
    req_i      = 1'b1;
    we_i       = 1'b0;
    addr_i     = 10'h104;
    transfer_i = 4'hF;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    check("pre_reset_sel", 64'(sel_o), 64'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("reset_sel_drop", 64'(sel_o), 64'd0);
    check("reset_busy_drop", 64'(busy_o), 64'd0);
    check("reset_transfer_drop", 64'(s_transfer_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_idle", 64'(busy_o), 64'd0);
    do_txn(vecs[0]);

    // A second request pulse while the first is in ACCESS must be dropped.
    @(negedge clk);
    cur_lat    = 3;
    req_i      = 1'b1;
    we_i       = 1'b0;
    addr_i     = 10'h104;
    transfer_i = 4'hF;
    sb.push_back({32'hDEADBEEF, 1'b0});
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    req_i  = 1'b1;
    we_i   = 1'b1;
    addr_i = 10'h300;
    @(negedge clk);
    req_i  = 1'b0;
    rcnt   = 0;
    selbad = 0;
    repeat (12) begin
      if (ready_o) rcnt++;
      if (sel_o !== 4'b0000 && sel_o !== 4'b0010) selbad++;
      @(negedge clk);
    end
    check("ignored_req_ready_count", 64'(rcnt), 64'd1);
    check("ignored_req_sel", 64'(selbad), 64'd0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
